// File: rtl/pmp_checker.sv
// PMP checker: NUM_ENTRIES OFF/TOR/NA4/NAPOT regions, checked in priority order, CSR-programmable.
// Latency 1, one check per cycle; req_ready drops only while a held response sees rsp_ready low.
module pmp_checker #(
  parameter int NUM_ENTRIES = 8,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              csr_we,
  input  logic              csr_re,
  input  logic              csr_sel,
  input  logic [3:0]        csr_idx,
  input  logic [ADDR_W-3:0] csr_wdata,
  output logic [ADDR_W-3:0] csr_rdata,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic [1:0]        req_type,
  input  logic              req_priv_m,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_allow,
  output logic              rsp_hit,
  output logic [3:0]        rsp_idx
);
  localparam int AW = ADDR_W - 2;
  localparam int EW = ADDR_W - 1;  // word address plus a carry bit for the access end
  localparam logic [1:0] A_TOR = 2'd1, A_NA4 = 2'd2, A_NAPOT = 2'd3;

  logic [AW-1:0] addr_q [NUM_ENTRIES];
  logic [AW-1:0] addr_d [NUM_ENTRIES];
  logic [7:0]    cfg_q  [NUM_ENTRIES];
  logic [7:0]    cfg_d  [NUM_ENTRIES];
  logic [AW-1:0] csr_rdata_q, csr_rdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_allow_q, rsp_allow_d;
  logic          rsp_hit_q, rsp_hit_d;
  logic [3:0]    rsp_idx_q, rsp_idx_d;

  logic [NUM_ENTRIES-1:0] addr_frozen;
  logic [7:0]             cfg_wval;

  // An address register that is the top of a locked TOR region cannot move.
  always_comb begin
    addr_frozen = '0;
    for (int i = 0; i < NUM_ENTRIES - 1; i++) begin
      addr_frozen[i] = cfg_q[i+1][7] && (cfg_q[i+1][4:3] == A_TOR);
    end
  end

  always_comb begin
    cfg_wval = {csr_wdata[7], 2'b00, csr_wdata[4:0]};
    if (cfg_wval[1] && !cfg_wval[0]) cfg_wval[1] = 1'b0;
    csr_rdata_d = csr_rdata_q;
    if (csr_re) csr_rdata_d = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      addr_d[i] = addr_q[i];
      cfg_d[i]  = cfg_q[i];
      if (csr_idx == 4'(i)) begin
        if (csr_re) csr_rdata_d = csr_sel ? {{(AW-8){1'b0}}, cfg_q[i]} : addr_q[i];
        if (csr_we && !cfg_q[i][7]) begin
          if (csr_sel) cfg_d[i] = cfg_wval;
          else if (!addr_frozen[i]) addr_d[i] = csr_wdata;
        end
      end
    end
  end

  logic [ADDR_W:0] hi_b;
  logic [EW-1:0]   lo_w, hi_w;
  logic [AW-1:0]   prev  [NUM_ENTRIES];
  logic [AW-1:0]   nmask [NUM_ENTRIES];
  logic [EW-1:0]   rlo   [NUM_ENTRIES];
  logic [EW-1:0]   rhi   [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] rvld, ovl, full;

  // Each entry is reduced to an inclusive word range [rlo, rhi].
  always_comb begin
    hi_b = {1'b0, req_addr} + (ADDR_W+1)'((4'd1 << req_size) - 4'd1);
    lo_w = {1'b0, req_addr[ADDR_W-1:2]};
    hi_w = EW'(hi_b >> 2);
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      prev[i]  = '0;
      nmask[i] = addr_q[i] ^ (addr_q[i] + AW'(1));
      rvld[i]  = 1'b0;
      rlo[i]   = '0;
      rhi[i]   = '0;
    end
    for (int i = 1; i < NUM_ENTRIES; i++) prev[i] = addr_q[i-1];
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      case (cfg_q[i][4:3])
        A_TOR: begin
          rvld[i] = prev[i] < addr_q[i];
          rlo[i]  = {1'b0, prev[i]};
          rhi[i]  = {1'b0, addr_q[i] - AW'(1)};
        end
        A_NA4: begin
          rvld[i] = 1'b1;
          rlo[i]  = {1'b0, addr_q[i]};
          rhi[i]  = {1'b0, addr_q[i]};
        end
        A_NAPOT: begin
          rvld[i] = 1'b1;
          rlo[i]  = {1'b0, addr_q[i] & ~nmask[i]};
          rhi[i]  = {1'b0, addr_q[i] | nmask[i]};
        end
        default: rvld[i] = 1'b0;
      endcase
      ovl[i]  = rvld[i] && (lo_w <= rhi[i]) && (hi_w >= rlo[i]);
      full[i] = rvld[i] && (lo_w >= rlo[i]) && (hi_w <= rhi[i]);
    end
  end

  logic       sel_hit, sel_full, sel_lock, sel_perm, chk_allow;
  logic [2:0] sel_rwx;
  logic [3:0] sel_idx;

  always_comb begin
    sel_hit  = 1'b0;
    sel_full = 1'b0;
    sel_lock = 1'b0;
    sel_rwx  = '0;
    sel_idx  = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (ovl[i]) begin
        sel_hit  = 1'b1;
        sel_full = full[i];
        sel_lock = cfg_q[i][7];
        sel_rwx  = cfg_q[i][2:0];
        sel_idx  = 4'(i);
      end
    end
    case (req_type)
      2'd0:    sel_perm = sel_rwx[0];
      2'd1:    sel_perm = sel_rwx[1];
      2'd2:    sel_perm = sel_rwx[2];
      default: sel_perm = 1'b0;
    endcase
    chk_allow = sel_hit ? (sel_full && ((!sel_lock && req_priv_m) || sel_perm)) : req_priv_m;
    if (req_size == 2'd3 || req_type == 2'd3) chk_allow = 1'b0;
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_allow_d = rsp_allow_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_idx_d   = rsp_idx_q;
    if (req_valid && req_ready) begin
      rsp_valid_d = 1'b1;
      rsp_allow_d = chk_allow;
      rsp_hit_d   = sel_hit;
      rsp_idx_d   = sel_idx;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        addr_q[i] <= '0;
        cfg_q[i]  <= '0;
      end
      csr_rdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_allow_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_idx_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        addr_q[i] <= addr_d[i];
        cfg_q[i]  <= cfg_d[i];
      end
      csr_rdata_q <= csr_rdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_allow_q <= rsp_allow_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_idx_q   <= rsp_idx_d;
    end
  end

  assign req_ready = !rsp_valid_q || rsp_ready;
  assign rsp_valid = rsp_valid_q;
  assign rsp_allow = rsp_allow_q;
  assign rsp_hit   = rsp_hit_q;
  assign rsp_idx   = rsp_idx_q;
  assign csr_rdata = csr_rdata_q;

endmodule

// File: doc/pmp_checker.md
Name: pmp_checker

Overview:
- Parametrised physical-memory-protection checker holding NUM_ENTRIES address/config entries, programmed through a CSR write/read port.
- Supports all four address-matching modes per entry: OFF, TOR, NA4 and NAPOT.
- Checks each load, store or fetch request against priority-ordered entries and returns a registered allow/deny response through a valid/ready handshake.
- Sits between the core's address-generation stage and the bus interface.

Parameters:
NUM_ENTRIES, 8, number of PMP entries (1..16).
ADDR_W, 32, physical address width (byte address); each pmpaddr register holds addr[ADDR_W-1:2].

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
csr_we  in  1  CSR write strobe
csr_re  in  1  CSR read strobe
csr_sel  in  1  0 = pmpaddr, 1 = pmpcfg
csr_idx  in  4  entry index
csr_wdata  in  ADDR_W-2  write data (cfg uses bits [7:0])
csr_rdata  out  ADDR_W-2  read data, registered
req_valid  in  1  check request valid
req_ready  out  1  checker can accept request
req_addr  in  ADDR_W  access byte address
req_size  in  2  log2 bytes: 0 = 1, 1 = 2, 2 = 4 (3 is illegal and is denied)
req_type  in  2  0 = read, 1 = write, 2 = exec (3 is denied)
req_priv_m  in  1  1 = machine mode
rsp_valid  out  1  response valid
rsp_ready  in  1  consumer accepts response
rsp_allow  out  1  access permitted
rsp_hit  out  1  some entry matched
rsp_idx  out  4  matching entry index (0 when rsp_hit = 0)

Behaviour:
- Clock and reset:
  - Single clock `clk`; asynchronous active-low reset `rst_n`.
  - Reset clears every cfg (A = OFF, L = 0) and every addr to 0.
  - Reset forces rsp_valid = 0, rsp_allow = 0, rsp_hit = 0, rsp_idx = 0, csr_rdata = 0. req_ready = 1 after reset.
- cfg byte layout: [0] R, [1] W, [2] X, [4:3] A (0 OFF, 1 TOR, 2 NA4, 3 NAPOT), [7] L. Bits [6:5] read as 0.
- CSR write rules:
  - Writes take effect at the next edge.
  - A write to entry i is ignored if cfg[i].L = 1.
  - A pmpaddr write to entry i is also ignored if cfg[i+1].L = 1 and cfg[i+1].A = TOR.
  - A cfg write with W = 1 and R = 0 is stored with W = 0 (WARL).
  - Any csr_idx >= NUM_ENTRIES: the write is ignored and reads return 0.
  - L is cleared only by reset.
- CSR read: csr_rdata updates one cycle after csr_re. When csr_re and csr_we target the same entry in the same cycle, the read returns the old value.
- Request/response handshake:
  - req_ready = !rsp_valid | rsp_ready.
  - A request is accepted when req_valid & req_ready. Its response appears on the next cycle: latency 1, throughput 1 per cycle.
  - rsp_* hold stable while rsp_valid & !rsp_ready.
  - rsp_valid falls when the response is consumed and no new request is accepted in that cycle.
- Match rules (access range lo = req_addr, hi = req_addr + 2^req_size - 1):
  - TOR: matches when prev <= lo>>2 and hi>>2 < addr[i]. prev = 0 for entry 0, else addr[i-1]. If prev >= addr[i], the entry never matches.
  - NA4: matches when lo>>2 == addr[i] and hi>>2 == addr[i].
  - NAPOT: k = count of trailing ones in addr[i]; region size is 2^(k+3) bytes with base = addr[i] with its low k+1 bits cleared. All-ones addr[i] covers the whole space.
  - Partial overlap with an entry (some bytes in, some out) counts as a match with allow = 0.
  - The lowest-index matching entry wins; rsp_idx = that index.
- Permission:
  - Matched entry, L = 0, M-mode: allow.
  - Matched entry otherwise: allow = the R/W/X bit selected by req_type.
  - No match: allow = req_priv_m.
  - req_size = 3 or req_type = 3: allow = 0, and rsp_hit still reflects matching.
- Simultaneous CSR write and accepted request: the request is checked against the pre-write configuration.
- Reset asserted mid-response: the response is dropped and not replayed.

Test Plan:
- Entry 0 NAPOT, addr = 0x0000_03FF (base 0x0, 8 KiB), cfg R = 1 W = 0 L = 1; U-mode write to 0x100 -> rsp_hit = 1, rsp_idx = 0, rsp_allow = 0. U-mode read to 0x100 -> allow = 1. M-mode write -> allow = 0 (locked).
- Entry 1 TOR with addr[0] = 0x400 (0x1000 byte), addr[1] = 0x800, X = 1; fetch at 0x1FFC size 2 -> allow = 1, idx = 1. Size 2 at 0x1FFE -> partial overlap -> allow = 0.
- Entries 2 and 3 both NA4 at 0x3000, entry 2 R = 0, entry 3 R = 1; U-mode read 0x3000 -> idx = 2, allow = 0.
- No entries enabled: M-mode read 0x8000_0000 -> hit = 0, allow = 1; U-mode -> allow = 0.
- Lock behaviour: set cfg[1] L = 1, A = TOR; write pmpaddr0 = 0x123, then read pmpaddr0 -> old value. Write cfg = 0x02 (W only) to unlocked entry 4 -> readback 0x00.
- Back-to-back requests with rsp_ready low for 3 cycles -> req_ready = 0, response held stable. Assert rst_n low mid-stall -> rsp_valid = 0 immediately, all cfg read back 0.
